// File: rtl/video_timing_pkg.sv
// Shared types and standard display-mode constants for the raster timing generator.
// Each mode carries porch/sync widths, sync polarities and the nominal pixel rate.
package video_timing_pkg;

   typedef struct packed {
      logic hsync;
      logic vsync;
      logic hblank;
      logic vblank;
      logic visible;
      logic line_start;
      logic frame_start;
   } timing_flags_t;

   typedef struct packed {
      int h_visible;
      int h_front;
      int h_sync;
      int h_back;
      int v_visible;
      int v_front;
      int v_sync;
      int v_back;
      bit h_pol;
      bit v_pol;
      int pix_khz;
   } video_mode_t;

   localparam video_mode_t MODE_640X480_60 = '{
      h_visible: 640, h_front: 16, h_sync: 96, h_back: 48,
      v_visible: 480, v_front: 10, v_sync: 2, v_back: 33,
      h_pol: 1'b0, v_pol: 1'b0, pix_khz: 25175};

   localparam video_mode_t MODE_800X600_60 = '{
      h_visible: 800, h_front: 40, h_sync: 128, h_back: 88,
      v_visible: 600, v_front: 1, v_sync: 4, v_back: 23,
      h_pol: 1'b1, v_pol: 1'b1, pix_khz: 40000};

   localparam video_mode_t MODE_1024X768_60 = '{
      h_visible: 1024, h_front: 24, h_sync: 136, h_back: 160,
      v_visible: 768, v_front: 3, v_sync: 6, v_back: 29,
      h_pol: 1'b0, v_pol: 1'b0, pix_khz: 65000};

   function automatic int mode_h_total(input video_mode_t m);
      return m.h_visible + m.h_front + m.h_sync + m.h_back;
   endfunction

   function automatic int mode_v_total(input video_mode_t m);
      return m.v_visible + m.v_front + m.v_sync + m.v_back;
   endfunction

endpackage

// File: rtl/timing_delay_line.sv
// Enable-gated WIDTH x DEPTH shift register with asynchronous reset to RST_VAL.
// DEPTH = 0 is a plain wire from input to output.
module timing_delay_line #(
   parameter int               WIDTH   = 1,
   parameter int               DEPTH   = 0,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_en,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   genvar gi;
   generate
      if (DEPTH == 0) begin : g_bypass
         logic unused_ctrl;
         assign unused_ctrl = &{1'b0, i_clk, i_rst_n, i_en};
         assign o_q = i_d;
      end else begin : g_shift
         logic [WIDTH-1:0] stage_reg [DEPTH];
         for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_head
               always_ff @(posedge i_clk or negedge i_rst_n) begin
                  if (!i_rst_n)  stage_reg[gi] <= RST_VAL;
                  else if (i_en) stage_reg[gi] <= i_d;
               end
            end else begin : g_tail
               always_ff @(posedge i_clk or negedge i_rst_n) begin
                  if (!i_rst_n)  stage_reg[gi] <= RST_VAL;
                  else if (i_en) stage_reg[gi] <= stage_reg[gi-1];
               end
            end
         end
         assign o_q = stage_reg[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/video_timing_generator.sv
// Parametrised raster timing generator: position counters, registered sync/blank flags
// decoded from the next position, optional flag delay line, and a frame counter.
module video_timing_generator
   import video_timing_pkg::*;
#(
   parameter int H_VISIBLE       = MODE_640X480_60.h_visible,
   parameter int H_FRONT_PORCH   = MODE_640X480_60.h_front,
   parameter int H_SYNC_TIME     = MODE_640X480_60.h_sync,
   parameter int H_BACK_PORCH    = MODE_640X480_60.h_back,
   parameter int V_VISIBLE       = MODE_640X480_60.v_visible,
   parameter int V_FRONT_PORCH   = MODE_640X480_60.v_front,
   parameter int V_SYNC_TIME     = MODE_640X480_60.v_sync,
   parameter int V_BACK_PORCH    = MODE_640X480_60.v_back,
   parameter bit H_SYNC_POL      = MODE_640X480_60.h_pol,
   parameter bit V_SYNC_POL      = MODE_640X480_60.v_pol,
   parameter int POS_WIDTH       = 11,
   parameter int SYNC_DELAY      = 0,
   parameter int FRAME_CNT_WIDTH = 8
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_pix_en,
   input  logic                       i_restart,
   output logic [POS_WIDTH-1:0]       o_hpos,
   output logic [POS_WIDTH-1:0]       o_vpos,
   output logic                       o_hsync,
   output logic                       o_vsync,
   output logic                       o_hblank,
   output logic                       o_vblank,
   output logic                       o_visible,
   output logic                       o_line_start,
   output logic                       o_frame_start,
   output logic [FRAME_CNT_WIDTH-1:0] o_frame_count
);

   localparam int H_SYNC_START = H_VISIBLE + H_FRONT_PORCH;
   localparam int H_SYNC_END   = H_SYNC_START + H_SYNC_TIME;
   localparam int H_TOTAL      = H_SYNC_END + H_BACK_PORCH;
   localparam int V_SYNC_START = V_VISIBLE + V_FRONT_PORCH;
   localparam int V_SYNC_END   = V_SYNC_START + V_SYNC_TIME;
   localparam int V_TOTAL      = V_SYNC_END + V_BACK_PORCH;

   localparam logic [POS_WIDTH-1:0] H_VIS_P   = POS_WIDTH'(H_VISIBLE);
   localparam logic [POS_WIDTH-1:0] H_SS_P    = POS_WIDTH'(H_SYNC_START);
   localparam logic [POS_WIDTH-1:0] H_SE_P    = POS_WIDTH'(H_SYNC_END);
   localparam logic [POS_WIDTH-1:0] H_LAST_P  = POS_WIDTH'(H_TOTAL - 1);
   localparam logic [POS_WIDTH-1:0] V_VIS_P   = POS_WIDTH'(V_VISIBLE);
   localparam logic [POS_WIDTH-1:0] V_SS_P    = POS_WIDTH'(V_SYNC_START);
   localparam logic [POS_WIDTH-1:0] V_SE_P    = POS_WIDTH'(V_SYNC_END);
   localparam logic [POS_WIDTH-1:0] V_LAST_P  = POS_WIDTH'(V_TOTAL - 1);

   generate
      if (H_VISIBLE < 1 || H_FRONT_PORCH < 1 || H_SYNC_TIME < 1 || H_BACK_PORCH < 1 ||
          V_VISIBLE < 1 || V_FRONT_PORCH < 1 || V_SYNC_TIME < 1 || V_BACK_PORCH < 1 ||
          SYNC_DELAY < 0 || SYNC_DELAY > 15 ||
          H_TOTAL - 1 >= (1 << POS_WIDTH) || V_TOTAL - 1 >= (1 << POS_WIDTH)) begin : g_param_check
         $error("video_timing_generator: illegal timing parameters or POS_WIDTH too narrow");
      end
   endgenerate

   // Sync XNOR polarity: in-range drives the active level, otherwise the inactive one.
   function automatic timing_flags_t decode(input logic [POS_WIDTH-1:0] h,
                                            input logic [POS_WIDTH-1:0] v);
      timing_flags_t f;
      f.hsync       = ((h >= H_SS_P) && (h < H_SE_P)) ~^ H_SYNC_POL;
      f.vsync       = ((v >= V_SS_P) && (v < V_SE_P)) ~^ V_SYNC_POL;
      f.hblank      = (h >= H_VIS_P);
      f.vblank      = (v >= V_VIS_P);
      f.visible     = !f.hblank && !f.vblank;
      f.line_start  = (h == '0);
      f.frame_start = (h == '0) && (v == '0);
      return f;
   endfunction

   localparam timing_flags_t FLAGS_RST = decode(H_LAST_P, V_LAST_P);

   logic [POS_WIDTH-1:0]       hpos_reg, hpos_next;
   logic [POS_WIDTH-1:0]       vpos_reg, vpos_next;
   logic [FRAME_CNT_WIDTH-1:0] frame_count_reg;
   timing_flags_t              flags_reg;
   timing_flags_t              flags_dly;
   logic                       frame_wrap;

   always_comb begin
      hpos_next = hpos_reg;
      vpos_next = vpos_reg;
      if (i_restart) begin
         hpos_next = '0;
         vpos_next = '0;
      end else if (hpos_reg == H_LAST_P) begin
         hpos_next = '0;
         vpos_next = (vpos_reg == V_LAST_P) ? '0 : vpos_reg + 1'b1;
      end else begin
         hpos_next = hpos_reg + 1'b1;
      end
   end

   // A restart that lands on the natural wrap still yields a single (0,0), so one count.
   assign frame_wrap = (hpos_next == '0) && (vpos_next == '0);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         hpos_reg        <= H_LAST_P;
         vpos_reg        <= V_LAST_P;
         flags_reg       <= FLAGS_RST;
         frame_count_reg <= '1;
      end else if (i_pix_en) begin
         hpos_reg  <= hpos_next;
         vpos_reg  <= vpos_next;
         flags_reg <= decode(hpos_next, vpos_next);
         if (frame_wrap) frame_count_reg <= frame_count_reg + 1'b1;
      end
   end

   timing_delay_line #(
      .WIDTH   ($bits(timing_flags_t)),
      .DEPTH   (SYNC_DELAY),
      .RST_VAL (FLAGS_RST)
   ) u_delay (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_en    (i_pix_en),
      .i_d     (flags_reg),
      .o_q     (flags_dly)
   );

   assign o_hpos        = hpos_reg;
   assign o_vpos        = vpos_reg;
   assign o_hsync       = flags_dly.hsync;
   assign o_vsync       = flags_dly.vsync;
   assign o_hblank      = flags_dly.hblank;
   assign o_vblank      = flags_dly.vblank;
   assign o_visible     = flags_dly.visible;
   assign o_line_start  = flags_dly.line_start;
   assign o_frame_start = flags_dly.frame_start;
   assign o_frame_count = frame_count_reg;

endmodule

// File: tb/tb_video_timing_generator.sv
// Directed bench: default 640x480 instance for line timing, a tiny-raster instance for
// frame/restart/wrap vectors, and a tiny delayed positive-sync instance for the delay line.
module tb_video_timing_generator;
   import video_timing_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n, pix_en, restart;

   logic [10:0] d0_hpos, d0_vpos;
   logic        d0_hs, d0_vs, d0_hb, d0_vb, d0_vis, d0_ls, d0_fs;
   logic [7:0]  d0_fc;
   logic [3:0]  d1_hpos, d1_vpos;
   logic        d1_hs, d1_vs, d1_hb, d1_vb, d1_vis, d1_ls, d1_fs;
   logic [7:0]  d1_fc;
   logic [3:0]  d2_hpos, d2_vpos;
   logic        d2_hs, d2_vs, d2_hb, d2_vb, d2_vis, d2_ls, d2_fs;
   logic [7:0]  d2_fc;

   video_timing_generator dut0 (
      .i_clk(clk), .i_rst_n(rst_n), .i_pix_en(pix_en), .i_restart(restart),
      .o_hpos(d0_hpos), .o_vpos(d0_vpos), .o_hsync(d0_hs), .o_vsync(d0_vs),
      .o_hblank(d0_hb), .o_vblank(d0_vb), .o_visible(d0_vis),
      .o_line_start(d0_ls), .o_frame_start(d0_fs), .o_frame_count(d0_fc));

   video_timing_generator #(
      .H_VISIBLE(8), .H_FRONT_PORCH(2), .H_SYNC_TIME(3), .H_BACK_PORCH(2),
      .V_VISIBLE(4), .V_FRONT_PORCH(1), .V_SYNC_TIME(2), .V_BACK_PORCH(1),
      .POS_WIDTH(4)
   ) dut1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_pix_en(pix_en), .i_restart(restart),
      .o_hpos(d1_hpos), .o_vpos(d1_vpos), .o_hsync(d1_hs), .o_vsync(d1_vs),
      .o_hblank(d1_hb), .o_vblank(d1_vb), .o_visible(d1_vis),
      .o_line_start(d1_ls), .o_frame_start(d1_fs), .o_frame_count(d1_fc));

   video_timing_generator #(
      .H_VISIBLE(8), .H_FRONT_PORCH(2), .H_SYNC_TIME(3), .H_BACK_PORCH(2),
      .V_VISIBLE(4), .V_FRONT_PORCH(1), .V_SYNC_TIME(2), .V_BACK_PORCH(1),
      .POS_WIDTH(4), .SYNC_DELAY(3), .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1)
   ) dut2 (
      .i_clk(clk), .i_rst_n(rst_n), .i_pix_en(pix_en), .i_restart(restart),
      .o_hpos(d2_hpos), .o_vpos(d2_vpos), .o_hsync(d2_hs), .o_vsync(d2_vs),
      .o_hblank(d2_hb), .o_vblank(d2_vb), .o_visible(d2_vis),
      .o_line_start(d2_ls), .o_frame_start(d2_fs), .o_frame_count(d2_fc));

   int n_vec  = 0;
   int n_miss = 0;

   task automatic chk(input string name, input logic [31:0] act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   typedef struct {
      logic en, rs;
      int   rep;
      int   h, v;
      logic hs, vs, hb, vb, vis, ls, fs;
      int   fc;
   } vec_t;

   vec_t tbl [27];

   initial begin
      int hs_low, hs_bad, vis_cnt, d2_pos_bad, d2_hs_bad, first_rise;
      int hold_bad, hs_low4, prev_h, exp_h;
      logic prev_hs, prev_hs2, exp_hs2;

      // en rs rep  h  v  hs vs hb vb vis ls fs  fc   (tiny raster: 15x8, sync low h10..12, v5..6)
      tbl[0]  = '{1,0,1,   0, 0, 1,1,0,0,1,1,1, 0};
      tbl[1]  = '{0,0,1,   0, 0, 1,1,0,0,1,1,1, 0};
      tbl[2]  = '{0,1,1,   0, 0, 1,1,0,0,1,1,1, 0};
      tbl[3]  = '{1,0,1,   1, 0, 1,1,0,0,1,0,0, 0};
      tbl[4]  = '{1,0,7,   8, 0, 1,1,1,0,0,0,0, 0};
      tbl[5]  = '{1,0,2,  10, 0, 0,1,1,0,0,0,0, 0};
      tbl[6]  = '{1,0,2,  12, 0, 0,1,1,0,0,0,0, 0};
      tbl[7]  = '{1,0,1,  13, 0, 1,1,1,0,0,0,0, 0};
      tbl[8]  = '{1,0,1,  14, 0, 1,1,1,0,0,0,0, 0};
      tbl[9]  = '{1,0,1,   0, 1, 1,1,0,0,1,1,0, 0};
      tbl[10] = '{1,0,45,  0, 4, 1,1,0,1,0,1,0, 0};
      tbl[11] = '{1,0,15,  0, 5, 1,0,0,1,0,1,0, 0};
      tbl[12] = '{1,0,14, 14, 5, 1,0,1,1,0,0,0, 0};
      tbl[13] = '{1,0,1,   0, 6, 1,0,0,1,0,1,0, 0};
      tbl[14] = '{1,0,15,  0, 7, 1,1,0,1,0,1,0, 0};
      tbl[15] = '{1,0,14, 14, 7, 1,1,1,1,0,0,0, 0};
      tbl[16] = '{1,0,1,   0, 0, 1,1,0,0,1,1,1, 1};
      tbl[17] = '{1,0,5,   5, 0, 1,1,0,0,1,0,0, 1};
      tbl[18] = '{1,1,1,   0, 0, 1,1,0,0,1,1,1, 2};
      tbl[19] = '{1,0,14, 14, 0, 1,1,1,0,0,0,0, 2};
      tbl[20] = '{1,0,105,14, 7, 1,1,1,1,0,0,0, 2};
      tbl[21] = '{1,1,1,   0, 0, 1,1,0,0,1,1,1, 3};
      tbl[22] = '{0,0,1,   0, 0, 1,1,0,0,1,1,1, 3};
      tbl[23] = '{1,0,1,   1, 0, 1,1,0,0,1,0,0, 3};
      tbl[24] = '{1,0,33,  4, 2, 1,1,0,0,1,0,0, 3};
      tbl[25] = '{1,1,1,   0, 0, 1,1,0,0,1,1,1, 4};
      tbl[26] = '{0,1,1,   0, 0, 1,1,0,0,1,1,1, 4};

      // Reset state
      rst_n = 1'b0; pix_en = 1'b0; restart = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst.d0.hpos", d0_hpos, 799);   chk("rst.d0.vpos", d0_vpos, 524);
      chk("rst.d0.hsync", d0_hs, 1);      chk("rst.d0.vsync", d0_vs, 1);
      chk("rst.d0.hblank", d0_hb, 1);     chk("rst.d0.vblank", d0_vb, 1);
      chk("rst.d0.visible", d0_vis, 0);   chk("rst.d0.line_start", d0_ls, 0);
      chk("rst.d0.frame_start", d0_fs, 0); chk("rst.d0.frame_count", d0_fc, 255);
      chk("rst.d1.hpos", d1_hpos, 14);    chk("rst.d1.vpos", d1_vpos, 7);
      chk("rst.d2.hsync", d2_hs, 0);      chk("rst.d2.vsync", d2_vs, 0);
      chk("rst.d2.hblank", d2_hb, 1);     chk("rst.d2.frame_count", d2_fc, 255);
      rst_n = 1'b1;

      // Table vectors on the tiny raster
      for (int i = 0; i < 27; i++) begin
         pix_en  = tbl[i].en;
         restart = tbl[i].rs;
         repeat (tbl[i].rep) tick();
         chk($sformatf("v%0d.hpos", i), d1_hpos, tbl[i].h);
         chk($sformatf("v%0d.vpos", i), d1_vpos, tbl[i].v);
         chk($sformatf("v%0d.hsync", i), d1_hs, int'(tbl[i].hs));
         chk($sformatf("v%0d.vsync", i), d1_vs, int'(tbl[i].vs));
         chk($sformatf("v%0d.hblank", i), d1_hb, int'(tbl[i].hb));
         chk($sformatf("v%0d.vblank", i), d1_vb, int'(tbl[i].vb));
         chk($sformatf("v%0d.visible", i), d1_vis, int'(tbl[i].vis));
         chk($sformatf("v%0d.line_start", i), d1_ls, int'(tbl[i].ls));
         chk($sformatf("v%0d.frame_start", i), d1_fs, int'(tbl[i].fs));
         chk($sformatf("v%0d.frame_count", i), d1_fc, tbl[i].fc);
      end
      restart = 1'b0;

      // One default line with pix_en tied high; delayed instance checked alongside
      pix_en = 1'b0; rst_n = 1'b0;
      tick();
      rst_n = 1'b1; pix_en = 1'b1;
      hs_low = 0; hs_bad = 0; vis_cnt = 0; d2_pos_bad = 0; d2_hs_bad = 0;
      first_rise = -1; prev_hs2 = 1'b0;
      for (int c = 0; c <= 800; c++) begin
         tick();
         if (c == 0) begin
            chk("first.hpos", d0_hpos, 0);        chk("first.vpos", d0_vpos, 0);
            chk("first.frame_start", d0_fs, 1);   chk("first.frame_count", d0_fc, 0);
            chk("first.line_start", d0_ls, 1);    chk("first.visible", d0_vis, 1);
         end
         if (c < 800) begin
            if (!d0_hs) begin
               hs_low++;
               if (d0_hpos < 656 || d0_hpos > 751) hs_bad++;
            end
            if (d0_vis) vis_cnt++;
            if (c == 799) chk("line.last_hpos", d0_hpos, 799);
         end else begin
            chk("line.wrap_hpos", d0_hpos, 0);   chk("line.wrap_vpos", d0_vpos, 1);
            chk("line.wrap_ls", d0_ls, 1);       chk("line.wrap_fs", d0_fs, 0);
         end
         if (d2_hpos != 4'(c % 15) || d2_vpos != 4'((c / 15) % 8)) d2_pos_bad++;
         exp_hs2 = (c >= 3) && ((c % 15 == 13) || (c % 15 == 14) || (c % 15 == 0));
         if (d2_hs !== exp_hs2) d2_hs_bad++;
         if (d2_hs && !prev_hs2 && first_rise < 0) first_rise = int'(d2_hpos);
         prev_hs2 = d2_hs;
      end
      chk("line.hsync_low_clocks", hs_low, 96);
      chk("line.hsync_out_of_range", hs_bad, 0);
      chk("line.visible_clocks", vis_cnt, 640);
      chk("dly.pos_sequence_errors", d2_pos_bad, 0);
      chk("dly.hsync_pattern_errors", d2_hs_bad, 0);
      chk("dly.hsync_rise_hpos", first_rise, 13);

      // Pixel enable every 4th clock over one default line
      hold_bad = 0; hs_low4 = 0;
      for (int k = 0; k < 3200; k++) begin
         pix_en  = (k % 4 == 0);
         prev_h  = int'(d0_hpos);
         prev_hs = d0_hs;
         tick();
         exp_h = pix_en ? (prev_h + 1) % 800 : prev_h;
         if (int'(d0_hpos) != exp_h) hold_bad++;
         if (!pix_en && d0_hs !== prev_hs) hold_bad++;
         if (!d0_hs) hs_low4++;
      end
      chk("en4.hold_errors", hold_bad, 0);
      chk("en4.hsync_low_clocks", hs_low4, 384);
      chk("en4.end_hpos", d0_hpos, 0);
      chk("en4.end_vpos", d0_vpos, 2);

      // Asynchronous reset mid-line, observed without any clock edge
      pix_en = 1'b1;
      repeat (320) tick();
      chk("mid.hpos_before", d0_hpos, 320);
      #2 rst_n = 1'b0;
      #1;
      chk("async.hpos", d0_hpos, 799);   chk("async.vpos", d0_vpos, 524);
      chk("async.hblank", d0_hb, 1);     chk("async.vblank", d0_vb, 1);
      chk("async.hsync", d0_hs, 1);      chk("async.vsync", d0_vs, 1);
      chk("async.visible", d0_vis, 0);   chk("async.frame_count", d0_fc, 255);
      chk("async.d1_hpos", d1_hpos, 14); chk("async.d2_hsync", d2_hs, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Frame counter across 256 tiny frames
      tick();
      chk("fc.first_count", d1_fc, 0);  chk("fc.first_fs", d1_fs, 1);
      repeat (120) tick();
      chk("fc.second_count", d1_fc, 1); chk("fc.second_fs", d1_fs, 1);
      chk("fc.second_hpos", d1_hpos, 0); chk("fc.second_vpos", d1_vpos, 0);
      repeat (254 * 120) tick();
      chk("fc.count_255", d1_fc, 255);
      repeat (120) tick();
      chk("fc.wrap_count", d1_fc, 0);   chk("fc.wrap_fs", d1_fs, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/video_timing_generator.md
Name: video_timing_generator

Overview:
Parametrised raster timing generator, the successor to the fixed 640x480 sync generator. It adds:
- configurable sync polarity;
- a pixel clock-enable, so one fast system clock can drive several pixel rates;
- a synchronous restart for genlock;
- frame-start and line-start markers plus a frame counter;
- a programmable delay on all timing flags, to line them up with downstream pixel pipelines.

It sits between the clock/reset logic and the pixel generators / VGA output stage.

Parameters:
H_VISIBLE, 640, active pixels per line
H_FRONT_PORCH, 16, pixels from end of active region to hsync start (borders folded in)
H_SYNC_TIME, 96, hsync width in pixels
H_BACK_PORCH, 48, pixels from hsync end to line end
V_VISIBLE, 480, active lines per frame
V_FRONT_PORCH, 10, lines from end of active region to vsync start
V_SYNC_TIME, 2, vsync width in lines
V_BACK_PORCH, 33, lines from vsync end to frame end
H_SYNC_POL, 0, active level of o_hsync (0 = active-low)
V_SYNC_POL, 0, active level of o_vsync
POS_WIDTH, 11, width of position counters; must hold H_TOTAL-1 and V_TOTAL-1, otherwise elaboration error
SYNC_DELAY, 0, extra pixel-enable stages applied to all flag outputs (0..15)
FRAME_CNT_WIDTH, 8, width of o_frame_count

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_pix_en  in  1  pixel enable; all state advances only on clocks where it is 1
i_restart  in  1  synchronous frame restart, qualified by i_pix_en
o_hpos  out  POS_WIDTH  current horizontal counter (never delayed)
o_vpos  out  POS_WIDTH  current vertical counter (never delayed)
o_hsync  out  1  horizontal sync, polarity per H_SYNC_POL
o_vsync  out  1  vertical sync, polarity per V_SYNC_POL
o_hblank  out  1  1 outside the horizontal active region
o_vblank  out  1  1 outside the vertical active region
o_visible  out  1  ~hblank & ~vblank
o_line_start  out  1  flag: described position has hpos == 0
o_frame_start  out  1  flag: described position is (0,0)
o_frame_count  out  FRAME_CNT_WIDTH  frames started since reset, modulo 2^FRAME_CNT_WIDTH

Behaviour:
- Derived constants:
  - H_SYNC_START = H_VISIBLE + H_FRONT_PORCH; H_SYNC_END = H_SYNC_START + H_SYNC_TIME; H_TOTAL = H_SYNC_END + H_BACK_PORCH.
  - V_* constants are derived the same way.
  - All timing parameters must be >= 1.
- Counters: on each clock with i_pix_en = 1:
  - hpos increments; at H_TOTAL-1 it wraps to 0 and vpos increments.
  - vpos wraps from V_TOTAL-1 to 0.
  - When i_pix_en = 0, all state holds.
- Restart: i_restart = 1 with i_pix_en = 1 forces the next position to (0,0).
  - This counts as one frame start, so the frame counter increments once, including when it coincides with the natural wrap.
  - i_restart without i_pix_en is ignored.
- Flag register: all flags are registered and decoded from the next-position value.
  - With SYNC_DELAY = 0, the flags describe the same position as o_hpos/o_vpos in the same cycle, with no combinational glitches.
  - hsync is active for hpos in [H_SYNC_START, H_SYNC_END).
  - vsync is active for vpos in [V_SYNC_START, V_SYNC_END); its edges coincide with hpos = 0.
  - hblank = hpos >= H_VISIBLE; vblank = vpos >= V_VISIBLE.
- Delay line: with SYNC_DELAY = N, the flags pass through N further stages that shift only when i_pix_en = 1.
  - Flags then describe the position N enabled cycles earlier; o_hpos/o_vpos are unaffected.
- Flags are levels that hold while i_pix_en = 0; consumers qualify o_line_start/o_frame_start with i_pix_en. With i_pix_en tied 1 they are single-cycle pulses.
- Reset (async assert; release is synchronised externally):
  - Counters go to (H_TOTAL-1, V_TOTAL-1).
  - The flag register and every delay stage go to the decode of that position: hblank = vblank = 1, visible = 0, syncs inactive (= ~POL), line/frame start = 0.
  - o_frame_count goes to all-ones.
  - The first enabled cycle after release therefore moves to (0,0): frame_start, and o_frame_count becomes 0.
- Reset mid-frame takes effect immediately, without waiting for a clock or pixel enable.

Decomposition:
- Shared include video_timing_pkg holds standard mode constants: 640x480@60 (default), 800x600@60, 1024x768@60. These cover porch/sync/polarity sets and the required pixel rates.
- One sub-module, timing_delay_line, is natural: a parametrised width x depth shift register with enable, async active-low reset to a parameter value, and a depth-0 pass-through. It implements SYNC_DELAY.

Test Plan:
1. Defaults, i_pix_en = 1, release reset:
   - First clock: o_hpos = 0, o_vpos = 0, o_frame_start = 1, o_frame_count = 0.
   - o_hsync is low exactly for hpos 656..751 (96 clocks); line period is 800 clocks.
2. Defaults:
   - o_vsync is low for lines 490..491, with edges at hpos = 0.
   - o_visible = 1 for exactly 640 clocks per line on lines 0..479 and 0 on lines 480..524.
   - Frame period is 420000 clocks; o_frame_count = 1 at the second frame_start.
3. i_pix_en high every 4th clock:
   - Positions advance once per 4 clocks and flags hold in between.
   - hsync active lasts 384 clocks.
   - o_frame_count wraps 255 -> 0 after 256 frames (FRAME_CNT_WIDTH = 8).
4. SYNC_DELAY = 3, H_SYNC_POL = 1:
   - o_hsync rises in the cycle where o_hpos = 659 and stays high for 96 enabled cycles.
   - o_hpos/o_vpos sequence is identical to SYNC_DELAY = 0.
5. Restart and reset:
   - i_restart with i_pix_en at position (300,100): next cycle (0,0), o_frame_start = 1, count +1.
   - i_restart during the natural wrap: count +1 only once.
6. Assert i_rst_n low mid-line at (320,200):
   - Outputs immediately show (799,524), blanks 1, syncs inactive, o_frame_count all-ones, with no clock needed.
